// File: rtl/store_buffer.sv
// store_buffer: four-entry FIFO write buffer sitting between the MEM stage
// and the single data_mem port. Stores retire into the buffer in one cycle
// and drain to memory whenever the port is not needed by a load. Loads are
// answered combinationally, taking data from the youngest buffered store to
// the same word when one exists.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int WORD  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            st_valid,
   input  logic [WORD-1:0] st_addr,
   input  logic [WORD-1:0] st_data,
   output logic            st_ready,
   input  logic            ld_valid,
   input  logic [WORD-1:0] ld_addr,
   output logic            ld_ready,
   output logic [WORD-1:0] ld_data,
   output logic            ld_fwd,
   output logic [WORD-1:0] mem_addr,
   output logic            mem_read_en,
   output logic            mem_write_en,
   output logic [WORD-1:0] mem_wdata,
   input  logic [WORD-1:0] mem_rdata,
   output logic            empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   // Entry storage: word address (byte offset dropped) and store data.
   logic [WORD-3:0] entry_addr [DEPTH];
   logic [WORD-1:0] entry_data [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;

   logic full;
   logic enq;
   logic drain;
   logic fwd_hit;
   logic [WORD-1:0] fwd_data;
   logic [PTR_W-1:0] fwd_idx;

   // Byte-offset bits of the addresses are don't-care for word accesses.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{st_addr[1:0], ld_addr[1:0]};

   // A full buffer claims the port even over a pending load, otherwise a
   // steady stream of loads could starve the drain forever.
   assign full     = (count == FULL_COUNT);
   assign drain    = (count != '0) && (full || !ld_valid);
   assign enq      = st_valid && !full;
   assign st_ready = !full;
   assign ld_ready = !full;
   assign empty    = (count == '0);

   // Pointer and occupancy update; enqueue and drain in the same cycle cancel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            tail <= tail + 1'b1;
         end
         if (drain) begin
            head <= head + 1'b1;
         end
         if (enq && !drain) begin
            count <= count + 1'b1;
         end else if (drain && !enq) begin
            count <= count - 1'b1;
         end
      end
   end

   // Entry payload needs no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (enq) begin
         entry_addr[tail] <= st_addr[WORD-1:2];
         entry_data[tail] <= st_data;
      end
   end

   // Walk valid entries oldest to youngest so the youngest match overrides.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head + PTR_W'(i);
         if (((PTR_W+1)'(i) < count) && (entry_addr[fwd_idx] == ld_addr[WORD-1:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = entry_data[fwd_idx];
         end
      end
   end

   assign ld_fwd  = fwd_hit;
   assign ld_data = fwd_hit ? fwd_data : mem_rdata;

   // Memory port mux: drain write has priority, then load read, else idle.
   always_comb begin
      mem_write_en = 1'b0;
      mem_read_en  = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      if (drain) begin
         mem_write_en = 1'b1;
         mem_addr     = {entry_addr[head], 2'b00};
         mem_wdata    = entry_data[head];
      end else if (ld_valid) begin
         mem_read_en = 1'b1;
         mem_addr    = {ld_addr[WORD-1:2], 2'b00};
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus a randomized run checked against
// a queue-based model of the buffer and a reference copy of data memory.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int WORD  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            st_valid;
   logic [WORD-1:0] st_addr;
   logic [WORD-1:0] st_data;
   logic            st_ready;
   logic            ld_valid;
   logic [WORD-1:0] ld_addr;
   logic            ld_ready;
   logic [WORD-1:0] ld_data;
   logic            ld_fwd;
   logic [WORD-1:0] mem_addr;
   logic            mem_read_en;
   logic            mem_write_en;
   logic [WORD-1:0] mem_wdata;
   logic [WORD-1:0] mem_rdata;
   logic            empty;

   int checks = 0;
   int errors = 0;

   store_buffer #(.DEPTH(DEPTH), .WORD(WORD)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
      .ld_data(ld_data), .ld_fwd(ld_fwd),
      .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .empty(empty)
   );

   always #5 clk = ~clk;

   // Environment data memory driven by the DUT port (1 KiB, combinational read).
   logic [31:0] ram [256] = '{default: 32'h0};
   always @(posedge clk) begin
      if (mem_write_en) ram[mem_addr[9:2]] <= mem_wdata;
   end
   assign mem_rdata = mem_read_en ? ram[mem_addr[9:2]] : 32'h0;

   // Reference model: pending stores in program order plus expected memory.
   logic [29:0] qa [$];
   logic [31:0] qd [$];
   logic [31:0] refmem [256] = '{default: 32'h0};

   logic        exp_full, exp_drain, exp_enq, exp_ren, exp_fwd, exp_empty;
   logic [31:0] exp_maddr, exp_wdata, exp_ldata;

   // Derive this cycle's expected behaviour from the pending-store queue.
   function void predict();
      exp_full  = (qa.size() == DEPTH);
      exp_empty = (qa.size() == 0);
      exp_drain = (qa.size() > 0) && (exp_full || !ld_valid);
      exp_enq   = st_valid && !exp_full;
      exp_ren   = !exp_drain && ld_valid;
      exp_maddr = 32'h0;
      exp_wdata = 32'h0;
      if (exp_drain) begin
         exp_maddr = {qa[0], 2'b00};
         exp_wdata = qd[0];
      end else if (exp_ren) begin
         exp_maddr = {ld_addr[31:2], 2'b00};
      end
      exp_fwd   = 1'b0;
      exp_ldata = exp_ren ? refmem[ld_addr[9:2]] : 32'h0;
      for (int i = qa.size() - 1; i >= 0; i--) begin
         if (!exp_fwd && qa[i] == ld_addr[31:2]) begin
            exp_fwd   = 1'b1;
            exp_ldata = qd[i];
         end
      end
   endfunction

   // Advance one clock edge and apply the same edge to the model.
   task tick();
      logic [29:0] wa;
      predict();
      @(posedge clk);
      if (exp_drain) begin
         wa = qa.pop_front();
         refmem[wa[7:0]] = qd.pop_front();
      end
      if (exp_enq) begin
         qa.push_back(st_addr[31:2]);
         qd.push_back(st_data);
      end
      #1;
   endtask

   task set_idle();
      st_valid = 1'b0;
      st_addr  = 32'h0;
      st_data  = 32'h0;
      ld_valid = 1'b0;
      ld_addr  = 32'h0;
   endtask

   task drain_all();
      set_idle();
      for (int i = 0; i < 2 * DEPTH && qa.size() > 0; i++) tick();
   endtask

   task test_reset();
      rst = 1'b1;
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_st_ready: got %b expected 1", st_ready); end
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ld_ready: got %b expected 1", ld_ready); end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
      checks++; if (ld_fwd !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_fwd: got %b expected 0", ld_fwd); end
      checks++; if (ld_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_ld_data: got %h expected 0", ld_data); end
      checks++; if ({mem_write_en, mem_read_en} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem_en: got %b expected 00", {mem_write_en, mem_read_en}); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task test_store_load();
      set_idle();
      st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF;
      tick();
      set_idle();
      ld_valid = 1'b1; ld_addr = 32'h102;
      #1;
      checks++; if (ld_fwd !== 1'b1) begin errors++; $display("[TB] FAIL st_ld_fwd: got %b expected 1", ld_fwd); end
      checks++; if (ld_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL st_ld_data: got %h expected deadbeef", ld_data); end
      checks++; if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin errors++; $display("[TB] FAIL st_ld_port: got rd=%b wr=%b expected rd=1 wr=0", mem_read_en, mem_write_en); end
      checks++; if (mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL st_ld_addr: got %h expected 100", mem_addr); end
      tick();
      drain_all();
      ld_valid = 1'b1; ld_addr = 32'h100;
      #1;
      checks++; if (ld_fwd !== 1'b0 || ld_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL st_ld_mem: got fwd=%b %h expected fwd=0 deadbeef", ld_fwd, ld_data); end
      tick();
   endtask

   task automatic test_youngest();
      logic [31:0] sa [3] = '{32'h40, 32'h40, 32'h80};
      logic [31:0] sd [3] = '{32'h1, 32'h2, 32'h3};
      set_idle();
      ld_valid = 1'b1; ld_addr = 32'h3F0;
      for (int k = 0; k < 3; k++) begin
         st_valid = 1'b1; st_addr = sa[k]; st_data = sd[k];
         tick();
      end
      st_valid = 1'b0;
      ld_addr = 32'h40;
      #1;
      checks++; if (ld_fwd !== 1'b1 || ld_data !== 32'h2) begin errors++; $display("[TB] FAIL youngest_fwd: got fwd=%b %h expected fwd=1 2", ld_fwd, ld_data); end
      set_idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (mem_write_en !== 1'b1 || mem_addr !== sa[k] || mem_wdata !== sd[k]) begin
            errors++;
            $display("[TB] FAIL youngest_drain%0d: got wr=%b %h/%h expected wr=1 %h/%h", k, mem_write_en, mem_addr, mem_wdata, sa[k], sd[k]);
         end
         tick();
      end
      ld_valid = 1'b1; ld_addr = 32'h40;
      #1;
      checks++; if (ld_fwd !== 1'b0 || ld_data !== 32'h2) begin errors++; $display("[TB] FAIL youngest_mem: got fwd=%b %h expected fwd=0 2", ld_fwd, ld_data); end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL youngest_empty: got %b expected 1", empty); end
      tick();
   endtask

   task test_full_stall();
      set_idle();
      ld_valid = 1'b1; ld_addr = 32'h3F0;
      for (int k = 0; k < 4; k++) begin
         st_valid = 1'b1; st_addr = 32'h50 + 32'(4 * k); st_data = 32'h11 + 32'(k);
         #1;
         checks++;
         if (st_ready !== 1'b1 || ld_ready !== 1'b1 || mem_write_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill%0d: got st_rdy=%b ld_rdy=%b wr=%b expected 1 1 0", k, st_ready, ld_ready, mem_write_en);
         end
         tick();
      end
      st_addr = 32'h60; st_data = 32'h99;
      #1;
      checks++; if (st_ready !== 1'b0 || ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got st=%b ld=%b expected 0 0", st_ready, ld_ready); end
      checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h50 || mem_wdata !== 32'h11) begin errors++; $display("[TB] FAIL full_drain: got wr=%b %h/%h expected wr=1 50/11", mem_write_en, mem_addr, mem_wdata); end
      tick();
      st_valid = 1'b0;
      #1;
      checks++; if (st_ready !== 1'b1 || ld_ready !== 1'b1 || mem_write_en !== 1'b0) begin errors++; $display("[TB] FAIL after_full: got st=%b ld=%b wr=%b expected 1 1 0", st_ready, ld_ready, mem_write_en); end
      drain_all();
   endtask

   task test_simultaneous();
      set_idle();
      ld_valid = 1'b1; ld_addr = 32'h3F0;
      st_valid = 1'b1; st_addr = 32'h70; st_data = 32'h21;
      tick();
      st_addr = 32'h74; st_data = 32'h22;
      tick();
      ld_valid = 1'b0;
      st_addr = 32'h78; st_data = 32'h23;
      #1;
      checks++; if (st_ready !== 1'b1 || mem_write_en !== 1'b1 || mem_addr !== 32'h70 || mem_wdata !== 32'h21) begin errors++; $display("[TB] FAIL simul_drain: got rdy=%b wr=%b %h/%h expected 1 1 70/21", st_ready, mem_write_en, mem_addr, mem_wdata); end
      tick();
      set_idle();
      #1;
      checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h74 || mem_wdata !== 32'h22 || empty !== 1'b0) begin errors++; $display("[TB] FAIL simul_next: got wr=%b %h/%h empty=%b expected 1 74/22 0", mem_write_en, mem_addr, mem_wdata, empty); end
      tick();
      checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h78 || mem_wdata !== 32'h23) begin errors++; $display("[TB] FAIL simul_last: got wr=%b %h/%h expected 1 78/23", mem_write_en, mem_addr, mem_wdata); end
      tick();
      checks++; if (empty !== 1'b1 || mem_write_en !== 1'b0) begin errors++; $display("[TB] FAIL simul_empty: got empty=%b wr=%b expected 1 0", empty, mem_write_en); end
   endtask

   task test_wrap();
      logic [31:0] ea;
      set_idle();
      for (int k = 0; k < 10; k++) begin
         st_valid = 1'b1; st_addr = 32'h300 + 32'(4 * (k % 3)); st_data = 32'hA000 + 32'(k);
         #1;
         ea = 32'h300 + 32'(4 * ((k + 2) % 3));
         checks++;
         if (k == 0 && mem_write_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_first: got wr=%b expected 0", mem_write_en);
         end else if (k > 0 && (mem_write_en !== 1'b1 || mem_addr !== ea || mem_wdata !== 32'hA000 + 32'(k - 1))) begin
            errors++;
            $display("[TB] FAIL wrap%0d: got wr=%b %h/%h expected 1 %h/%h", k, mem_write_en, mem_addr, mem_wdata, ea, 32'hA000 + 32'(k - 1));
         end
         tick();
      end
      ld_valid = 1'b1; ld_addr = 32'h3F0;
      st_addr = 32'h310; st_data = 32'hB0;
      tick();
      st_addr = 32'h300; st_data = 32'hB2;
      tick();
      st_valid = 1'b0;
      ld_addr = 32'h300;
      #1;
      checks++; if (ld_fwd !== 1'b1 || ld_data !== 32'hB2) begin errors++; $display("[TB] FAIL wrap_fwd: got fwd=%b %h expected 1 b2", ld_fwd, ld_data); end
      ld_addr = 32'h304;
      #1;
      checks++; if (ld_fwd !== 1'b0 || ld_data !== 32'hA007) begin errors++; $display("[TB] FAIL wrap_mem: got fwd=%b %h expected 0 a007", ld_fwd, ld_data); end
      drain_all();
   endtask

   task test_reset_mid_drain();
      set_idle();
      ld_valid = 1'b1; ld_addr = 32'h3F0;
      for (int k = 0; k < 3; k++) begin
         st_valid = 1'b1; st_addr = 32'h90 + 32'(4 * k); st_data = 32'hC0 + 32'(k);
         tick();
      end
      set_idle();
      #1;
      checks++; if (mem_write_en !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_drain: got %b expected 1", mem_write_en); end
      #1 rst = 1'b1;
      #1;
      qa.delete();
      qd.delete();
      checks++; if (mem_write_en !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_mem: got wr=%b %h expected 0 0", mem_write_en, mem_addr); end
      checks++; if (empty !== 1'b1 || st_ready !== 1'b1 || ld_fwd !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state: got empty=%b rdy=%b fwd=%b expected 1 1 0", empty, st_ready, ld_fwd); end
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      ld_valid = 1'b1; ld_addr = 32'h90;
      #1;
      checks++; if (ld_fwd !== 1'b0 || ld_data !== 32'h0) begin errors++; $display("[TB] FAIL discarded: got fwd=%b %h expected 0 0", ld_fwd, ld_data); end
      tick();
   endtask

   task test_random();
      for (int c = 0; c < 400; c++) begin
         st_valid = ($urandom_range(0, 1) == 1);
         st_addr  = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         st_data  = $urandom;
         ld_valid = ($urandom_range(0, 3) != 0);
         ld_addr  = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         #1;
         predict();
         checks++;
         if (st_ready !== !exp_full || ld_ready !== !exp_full || empty !== exp_empty) begin
            errors++;
            $display("[TB] FAIL rnd_status c=%0d: got st=%b ld=%b empty=%b expected %b %b %b", c, st_ready, ld_ready, empty, !exp_full, !exp_full, exp_empty);
         end
         checks++;
         if (mem_write_en !== exp_drain || mem_read_en !== exp_ren || mem_addr !== exp_maddr || mem_wdata !== exp_wdata) begin
            errors++;
            $display("[TB] FAIL rnd_port c=%0d: got wr=%b rd=%b %h/%h expected %b %b %h/%h", c, mem_write_en, mem_read_en, mem_addr, mem_wdata, exp_drain, exp_ren, exp_maddr, exp_wdata);
         end
         if (ld_valid && !exp_full) begin
            checks++;
            if (ld_fwd !== exp_fwd || ld_data !== exp_ldata) begin
               errors++;
               $display("[TB] FAIL rnd_load c=%0d: got fwd=%b %h expected %b %h", c, ld_fwd, ld_data, exp_fwd, exp_ldata);
            end
         end
         tick();
      end
      drain_all();
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rnd_final_empty: got %b expected 1", empty); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_store_load();
      test_youngest();
      test_full_stall();
      test_simultaneous();
      test_wrap();
      test_reset_mid_drain();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
